// File: rtl/id_hazard_if.sv
// id_hazard_if: decode-stage issue/hazard signal bundle between the ID stage
// (master) and the issue controller (slave).
interface id_hazard_if #(
    parameter int unsigned AW = 5
);
    logic          id_valid;
    logic [AW-1:0] rs1;
    logic          rs1_valid;
    logic [AW-1:0] rs2;
    logic          rs2_valid;
    logic [AW-1:0] rd;
    logic          rd_valid;
    logic          is_wfi;
    logic          ex_ready;
    logic          flush;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic          irq_pend;
    logic          stallreq;
    logic          issue;
    logic          sleeping;
    logic          sb_busy;
    logic          sb_err;
    logic          fwd_rs1;
    logic          fwd_rs2;

    // ID stage / pipeline side
    modport master (
        output id_valid, rs1, rs1_valid, rs2, rs2_valid, rd, rd_valid, is_wfi,
        output ex_ready, flush, wb_valid, wb_rd, irq_pend,
        input  stallreq, issue, sleeping, sb_busy, sb_err, fwd_rs1, fwd_rs2
    );

    // issue controller side
    modport slave (
        input  id_valid, rs1, rs1_valid, rs2, rs2_valid, rd, rd_valid, is_wfi,
        input  ex_ready, flush, wb_valid, wb_rd, irq_pend,
        output stallreq, issue, sleeping, sb_busy, sb_err, fwd_rs1, fwd_rs2
    );
endinterface

// File: rtl/id_hazard_ctrl.sv
// id_hazard_ctrl: decode-stage issue controller.
//  - per-register scoreboard of in-flight writes (x0 never tracked)
//  - RAW / counter-full stall generation, ID->EX issue
//  - WFI sequence: drain outstanding writes, sleep, wake on interrupt
// Optional feature macro: ID_HAZARD_BYPASS_EN
//  defined   : a RAW on a register whose last in-flight write is retiring this
//              cycle is waived and the source takes the WB bypass (fwd_rsX=1)
//  undefined : fwd_rs1/fwd_rs2 tied to 0, RAW clears the cycle after the count hits 0
module id_hazard_ctrl #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    id_hazard_if.slave  bus
);

    localparam int unsigned IW = $clog2(NREGS);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SLEEP = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             wfi_done_q, wfi_done_d;
    logic             sb_err_q, sb_err_d;
    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];

    logic rs1_busy_c, rs2_busy_c;
    logic fwd1_c, fwd2_c;
    logic raw_c, full_c;
    logic in_run_c, wfi_retire_c;
    logic stall_c, issue_c;
    logic busy_c, busy_next_c;
    logic inc_c, dec_c, wb_zero_c, same_reg_c;

    // Hazard detection, stall and issue decisions for the instruction in ID
    always_comb begin
        busy_c = 1'b0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            busy_c = busy_c | (cnt_q[IW'(i)] != '0);
        end

        rs1_busy_c = bus.rs1_valid && (bus.rs1 != '0) && (cnt_q[bus.rs1] != '0);
        rs2_busy_c = bus.rs2_valid && (bus.rs2 != '0) && (cnt_q[bus.rs2] != '0);

`ifdef ID_HAZARD_BYPASS_EN
        // Only the last outstanding write may be bypassed; older ones still stall.
        fwd1_c = bus.rs1_valid && (bus.rs1 != '0) && bus.wb_valid &&
                 (bus.wb_rd == bus.rs1) && (cnt_q[bus.rs1] == CNT_ONE);
        fwd2_c = bus.rs2_valid && (bus.rs2 != '0) && bus.wb_valid &&
                 (bus.wb_rd == bus.rs2) && (cnt_q[bus.rs2] == CNT_ONE);
`else
        fwd1_c = 1'b0;
        fwd2_c = 1'b0;
`endif

        raw_c  = (rs1_busy_c && !fwd1_c) || (rs2_busy_c && !fwd2_c);
        full_c = bus.rd_valid && (bus.rd != '0) && (cnt_q[bus.rd] == CNT_MAX);

        in_run_c = (state_q == ST_RUN);
        // First RUN cycle after a wake: the WFI still in ID leaves without stalling.
        wfi_retire_c = in_run_c && wfi_done_q && bus.is_wfi;

        stall_c = rst_n && bus.id_valid && !bus.flush && !wfi_retire_c &&
                  (raw_c || full_c || !bus.ex_ready || !in_run_c ||
                   (bus.is_wfi && in_run_c));
        issue_c = rst_n && bus.id_valid && !bus.flush && !stall_c && !bus.is_wfi;
    end

    // Scoreboard counter update and sticky write-back error
    always_comb begin
        sb_err_d = sb_err_q;
        for (int unsigned i = 0; i < NREGS; i++) begin
            cnt_d[IW'(i)] = cnt_q[IW'(i)];
        end

        inc_c      = issue_c && bus.rd_valid && (bus.rd != '0);
        dec_c      = bus.wb_valid && (bus.wb_rd != '0) && (cnt_q[bus.wb_rd] != '0);
        wb_zero_c  = bus.wb_valid && (bus.wb_rd != '0) && (cnt_q[bus.wb_rd] == '0);
        same_reg_c = inc_c && dec_c && (bus.rd == bus.wb_rd);

        // Issue and retire on the same register cancel out.
        if (inc_c && !same_reg_c) begin
            cnt_d[bus.rd] = cnt_q[bus.rd] + CNT_ONE;
        end
        if (dec_c && !same_reg_c) begin
            cnt_d[bus.wb_rd] = cnt_q[bus.wb_rd] - CNT_ONE;
        end
        if (wb_zero_c) begin
            sb_err_d = 1'b1;
        end

        busy_next_c = 1'b0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            busy_next_c = busy_next_c | (cnt_d[IW'(i)] != '0);
        end
    end

    // WFI sequencer next state; a wake (not a flush) marks the WFI for retirement
    always_comb begin
        state_d    = state_q;
        wfi_done_d = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (bus.id_valid && bus.is_wfi && !bus.flush && !wfi_done_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Interrupt wins over sleeping: wake straight from the drain.
                if (bus.flush) begin
                    state_d = ST_RUN;
                end else if (bus.irq_pend) begin
                    state_d    = ST_RUN;
                    wfi_done_d = 1'b1;
                end else if (!busy_next_c) begin
                    state_d = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (bus.flush) begin
                    state_d = ST_RUN;
                end else if (bus.irq_pend) begin
                    state_d    = ST_RUN;
                    wfi_done_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State, scoreboard and error flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wfi_done_q <= 1'b0;
            sb_err_q   <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                cnt_q[IW'(i)] <= '0;
            end
        end else begin
            state_q    <= state_d;
            wfi_done_q <= wfi_done_d;
            sb_err_q   <= sb_err_d;
            for (int unsigned i = 0; i < NREGS; i++) begin
                cnt_q[IW'(i)] <= cnt_d[IW'(i)];
            end
        end
    end

    // Outputs are forced low while reset is asserted
    assign bus.stallreq = stall_c;
    assign bus.issue    = issue_c;
    assign bus.sleeping = rst_n && (state_q == ST_SLEEP);
    assign bus.sb_busy  = rst_n && busy_c;
    assign bus.sb_err   = sb_err_q;
    assign bus.fwd_rs1  = rst_n && bus.id_valid && fwd1_c;
    assign bus.fwd_rs2  = rst_n && bus.id_valid && fwd2_c;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// tb_id_hazard_ctrl: directed scenarios plus randomized traffic checked against
// a behavioural scoreboard / WFI model. Define ID_HAZARD_BYPASS_EN for both
// bench and design to check the bypass build.
module tb_id_hazard_ctrl;

    localparam int MAXC     = 3;
    localparam int MD_RUN   = 0;
    localparam int MD_DRAIN = 1;
    localparam int MD_SLEEP = 2;

    logic clk;
    logic rst_n;

    id_hazard_if bus_if ();

    id_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // reference model state
    int cnt_m [32];
    int mode_m;
    bit woke_m;
    bit err_m;

    bit e_stall, e_issue, e_sleep, e_busy, e_fwd1, e_fwd2;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0b exp=%0b t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr_inputs();
        bus_if.id_valid  = 1'b0;
        bus_if.rs1       = '0;
        bus_if.rs1_valid = 1'b0;
        bus_if.rs2       = '0;
        bus_if.rs2_valid = 1'b0;
        bus_if.rd        = '0;
        bus_if.rd_valid  = 1'b0;
        bus_if.is_wfi    = 1'b0;
        bus_if.ex_ready  = 1'b1;
        bus_if.flush     = 1'b0;
        bus_if.wb_valid  = 1'b0;
        bus_if.wb_rd     = '0;
        bus_if.irq_pend  = 1'b0;
    endtask

    task automatic model_reset();
        foreach (cnt_m[i]) cnt_m[i] = 0;
        mode_m = MD_RUN;
        woke_m = 1'b0;
        err_m  = 1'b0;
    endtask

    // Expected combinational outputs from the rules applied to the current inputs
    task automatic model_eval();
        int  r1, r2, d;
        bit  h1, h2, f1, f2, full, blocked, retire;
        int  total;
        r1 = int'(bus_if.rs1);
        r2 = int'(bus_if.rs2);
        d  = int'(bus_if.rd);
        h1 = bus_if.rs1_valid && r1 != 0 && cnt_m[r1] != 0;
        h2 = bus_if.rs2_valid && r2 != 0 && cnt_m[r2] != 0;
        f1 = 1'b0;
        f2 = 1'b0;
`ifdef ID_HAZARD_BYPASS_EN
        f1 = h1 && bus_if.wb_valid && int'(bus_if.wb_rd) == r1 && cnt_m[r1] == 1;
        f2 = h2 && bus_if.wb_valid && int'(bus_if.wb_rd) == r2 && cnt_m[r2] == 1;
`endif
        full = bus_if.rd_valid && d != 0 && cnt_m[d] == MAXC;
        retire = (mode_m == MD_RUN) && woke_m && bus_if.is_wfi;
        blocked = (h1 && !f1) || (h2 && !f2) || full || !bus_if.ex_ready ||
                  (mode_m != MD_RUN) || (bus_if.is_wfi && mode_m == MD_RUN);
        e_stall = bus_if.id_valid && !bus_if.flush && !retire && blocked;
        e_issue = bus_if.id_valid && !bus_if.flush && !e_stall && !bus_if.is_wfi;
        e_fwd1  = bus_if.id_valid && f1;
        e_fwd2  = bus_if.id_valid && f2;
        e_sleep = (mode_m == MD_SLEEP);
        total = 0;
        foreach (cnt_m[i]) total += cnt_m[i];
        e_busy = (total != 0);
    endtask

    // Advance the model across one rising edge
    task automatic model_step();
        int  w, d, total;
        bit  woke_next;
        w = int'(bus_if.wb_rd);
        d = int'(bus_if.rd);
        if (bus_if.wb_valid && w != 0) begin
            if (cnt_m[w] > 0) cnt_m[w] -= 1;
            else              err_m = 1'b1;
        end
        if (e_issue && bus_if.rd_valid && d != 0) cnt_m[d] += 1;
        total = 0;
        foreach (cnt_m[i]) total += cnt_m[i];
        woke_next = 1'b0;
        case (mode_m)
            MD_RUN:   if (bus_if.id_valid && bus_if.is_wfi && !bus_if.flush && !woke_m)
                          mode_m = MD_DRAIN;
            MD_DRAIN: if (bus_if.flush) mode_m = MD_RUN;
                      else if (bus_if.irq_pend) begin mode_m = MD_RUN; woke_next = 1'b1; end
                      else if (total == 0) mode_m = MD_SLEEP;
            default:  if (bus_if.flush) mode_m = MD_RUN;
                      else if (bus_if.irq_pend) begin mode_m = MD_RUN; woke_next = 1'b1; end
        endcase
        woke_m = woke_next;
    endtask

    // Inputs are set at the falling edge; check shortly after, then cross the rising edge
    task automatic tick(input string tag);
        #1;
        model_eval();
        check_eq({tag, ".stallreq"}, bus_if.stallreq, e_stall);
        check_eq({tag, ".issue"},    bus_if.issue,    e_issue);
        check_eq({tag, ".sleeping"}, bus_if.sleeping, e_sleep);
        check_eq({tag, ".sb_busy"},  bus_if.sb_busy,  e_busy);
        check_eq({tag, ".sb_err"},   bus_if.sb_err,   err_m);
        check_eq({tag, ".fwd_rs1"},  bus_if.fwd_rs1,  e_fwd1);
        check_eq({tag, ".fwd_rs2"},  bus_if.fwd_rs2,  e_fwd2);
        model_step();
        @(negedge clk);
    endtask

    // Assert reset with a stall-provoking input pattern; every output must read 0
    task automatic apply_reset(input string tag);
        bus_if.id_valid = 1'b1;
        bus_if.ex_ready = 1'b0;
        bus_if.is_wfi   = 1'b1;
        rst_n = 1'b0;
        #1;
        check_eq({tag, ".rst_stallreq"}, bus_if.stallreq, 1'b0);
        check_eq({tag, ".rst_issue"},    bus_if.issue,    1'b0);
        check_eq({tag, ".rst_sleeping"}, bus_if.sleeping, 1'b0);
        check_eq({tag, ".rst_sb_busy"},  bus_if.sb_busy,  1'b0);
        check_eq({tag, ".rst_sb_err"},   bus_if.sb_err,   1'b0);
        check_eq({tag, ".rst_fwd_rs1"},  bus_if.fwd_rs1,  1'b0);
        check_eq({tag, ".rst_fwd_rs2"},  bus_if.fwd_rs2,  1'b0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        clr_inputs();
        @(negedge clk);
    endtask

    task automatic put_issue(input int d);
        clr_inputs();
        bus_if.id_valid = 1'b1;
        bus_if.rd       = 5'(d);
        bus_if.rd_valid = 1'b1;
    endtask

    task automatic put_wfi();
        clr_inputs();
        bus_if.id_valid = 1'b1;
        bus_if.is_wfi   = 1'b1;
    endtask

    initial begin
        int busy_list[$];
        checks = 0;
        errors = 0;
        model_reset();
        clr_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        apply_reset("init");

        // 1: RAW on x5, cleared by its write-back
        put_issue(5);                                     tick("t1_issue");
        clr_inputs(); bus_if.id_valid = 1'b1;
        bus_if.rs1 = 5'd5; bus_if.rs1_valid = 1'b1;       tick("t1_raw");
        bus_if.wb_valid = 1'b1; bus_if.wb_rd = 5'd5;      tick("t1_wb");
        bus_if.wb_valid = 1'b0;                           tick("t1_after");

        // 2: counter saturation and net-zero update on x3
        apply_reset("t2");
        repeat (3) begin put_issue(3); tick("t2_fill"); end
        put_issue(3);                                     tick("t2_full");
        clr_inputs(); bus_if.wb_valid = 1'b1; bus_if.wb_rd = 5'd3; tick("t2_wb");
        put_issue(3); bus_if.wb_valid = 1'b1; bus_if.wb_rd = 5'd3; tick("t2_net0");
        put_issue(3);                                     tick("t2_refill");
        put_issue(3);                                     tick("t2_full2");

        // 3: x0 never tracked, write-back to an idle register is sticky
        apply_reset("t3");
        for (int i = 0; i < 4; i++) begin
            put_issue(0); bus_if.rs1 = 5'd0; bus_if.rs1_valid = 1'b1; tick("t3_x0");
        end
        clr_inputs(); bus_if.wb_valid = 1'b1; bus_if.wb_rd = 5'd7; tick("t3_badwb");
        clr_inputs();                                     tick("t3_hold1");
        tick("t3_hold2");

        // 4: full WFI sequence with one write in flight
        apply_reset("t4");
        put_issue(9);                                     tick("t4_issue");
        put_wfi();                                        tick("t4_wfi");
        tick("t4_drain");
        bus_if.wb_valid = 1'b1; bus_if.wb_rd = 5'd9;      tick("t4_wb");
        bus_if.wb_valid = 1'b0;                           tick("t4_sleep");
        bus_if.irq_pend = 1'b1;                           tick("t4_irq");
        tick("t4_resume");
        clr_inputs();                                     tick("t4_run");

        // 5: flush out of SLEEP; interrupt out of DRAIN keeps counters
        apply_reset("t5");
        put_wfi();                                        tick("t5_wfi");
        tick("t5_drain");
        tick("t5_sleep");
        bus_if.flush = 1'b1;                              tick("t5_flush");
        clr_inputs();                                     tick("t5_run");
        put_issue(6);                                     tick("t5_issue");
        put_wfi();                                        tick("t5_wfi2");
        bus_if.irq_pend = 1'b1;                           tick("t5_irq");
        tick("t5_resume");
        clr_inputs(); bus_if.id_valid = 1'b1;
        bus_if.rs2 = 5'd6; bus_if.rs2_valid = 1'b1;       tick("t5_kept");

        // 6: reset in the middle of a drain
        apply_reset("t6a");
        put_issue(4);                                     tick("t6_i1");
        put_issue(4);                                     tick("t6_i2");
        put_wfi();                                        tick("t6_wfi");
        tick("t6_drain");
        apply_reset("t6");
        clr_inputs(); bus_if.id_valid = 1'b1;
        bus_if.rs1 = 5'd4; bus_if.rs1_valid = 1'b1;       tick("t6_post");

        // randomized traffic
        apply_reset("rnd");
        for (int n = 0; n < 2000; n++) begin
            if (n == 1000) apply_reset("rnd_mid");
            bus_if.id_valid  = ($urandom_range(0, 9) < 8);
            bus_if.rs1       = 5'($urandom_range(0, 7));
            bus_if.rs1_valid = $urandom_range(0, 1) == 1;
            bus_if.rs2       = 5'($urandom_range(0, 7));
            bus_if.rs2_valid = $urandom_range(0, 1) == 1;
            bus_if.rd        = 5'($urandom_range(0, 7));
            bus_if.rd_valid  = $urandom_range(0, 3) != 0;
            bus_if.is_wfi    = $urandom_range(0, 24) == 0;
            bus_if.ex_ready  = $urandom_range(0, 9) != 0;
            bus_if.flush     = $urandom_range(0, 29) == 0;
            bus_if.irq_pend  = $urandom_range(0, 14) == 0;
            bus_if.wb_valid  = $urandom_range(0, 2) == 0;
            busy_list = {};
            for (int i = 1; i < 32; i++) if (cnt_m[i] > 0) busy_list.push_back(i);
            if (busy_list.size() > 0 && $urandom_range(0, 19) != 0)
                bus_if.wb_rd = 5'(busy_list[$urandom_range(0, busy_list.size() - 1)]);
            else
                bus_if.wb_rd = 5'($urandom_range(0, 7));
            tick("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
